// File: rtl/except_ctrl_if.sv
// Fetch redirect handshake between the MEM-stage
// exception controller and the fetch unit.
interface except_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: prioritises causes,
// builds the CP0 request and holds the fetch redirect.
module except_ctrl #(
  parameter logic [31:0] VEC_BEV  = 32'hBFC00380,
  parameter logic [31:0] VEC_NORM = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_branch,
  input  logic        mem_if_adel,
  input  logic        mem_ri,
  input  logic        mem_syscall,
  input  logic        mem_break,
  input  logic        mem_ov,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic        mem_eret,
  input  logic [31:0] mem_badaddr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        except_flush,
  output logic        except_eret,
  output logic        except_delayslot,
  output logic [31:0] except_cur_pc,
  output logic [4:0]  except_code,
  output logic [31:0] except_extra,
  except_ctrl_if.master rd
);

  typedef enum logic {IDLE, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic        int_q, int_d;
  logic        ds_q, ds_d;
  logic [31:0] rpc_q, rpc_d;

  logic st_ie, st_exl, st_erl, st_bev;
  logic cause_int, any_cause, take;

  assign st_ie  = cp0_status[0];
  assign st_exl = cp0_status[1];
  assign st_erl = cp0_status[2];
  assign st_bev = cp0_status[22];

  logic unused_ok;
  assign unused_ok = ^{cp0_status[31:23], cp0_status[21:16],
                       cp0_status[7:3], cp0_cause[31:16],
                       cp0_cause[7:0]};

  // Cause prioritisation and CP0 request build
  always_comb begin
    int_d = |(cp0_cause[15:8] & cp0_status[15:8])
            & st_ie & ~st_exl & ~st_erl;
    cause_int = int_q & st_ie & ~st_exl;
    any_cause = cause_int | mem_if_adel | mem_ri
              | mem_syscall | mem_break | mem_ov
              | mem_adel | mem_ades | mem_eret;
    // reset also masks the request so CP0 never commits under rst
    take = ~rst & (state_q == IDLE) & mem_valid
         & ~mem_stall & any_cause;

    except_flush     = take;
    except_eret      = 1'b0;
    except_delayslot = 1'b0;
    except_cur_pc    = 32'h0;
    except_code      = 5'd0;
    except_extra     = 32'h0;

    if (take) begin
      except_delayslot = ds_q;
      except_cur_pc    = mem_pc;
      if (cause_int) begin
        except_code = 5'd0;
      end else if (mem_if_adel) begin
        except_code  = 5'd4;
        except_extra = mem_pc;
      end else if (mem_ri) begin
        except_code = 5'd10;
      end else if (mem_syscall) begin
        except_code = 5'd8;
      end else if (mem_break) begin
        except_code = 5'd9;
      end else if (mem_ov) begin
        except_code = 5'd12;
      end else if (mem_adel) begin
        except_code  = 5'd4;
        except_extra = mem_badaddr;
      end else if (mem_ades) begin
        except_code  = 5'd5;
        except_extra = mem_badaddr;
      end else begin
        except_eret = 1'b1;
      end
    end
  end

  // Next state, redirect target and delay-slot tracking
  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    ds_d    = ds_q;

    if (except_flush) begin
      ds_d = 1'b0;
    end else if (mem_valid && !mem_stall) begin
      ds_d = mem_is_branch;
    end

    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = REDIRECT;
          if (except_eret) begin
            rpc_d = cp0_epc;
          end else if (st_bev) begin
            rpc_d = VEC_BEV;
          end else begin
            rpc_d = VEC_NORM;
          end
        end
      end
      REDIRECT: begin
        if (rd.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      ds_q    <= 1'b0;
      rpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      ds_q    <= ds_d;
      rpc_q   <= rpc_d;
    end
  end

  assign rd.redirect_valid = (state_q == REDIRECT);
  assign rd.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: vector table
// with a scoreboard queue plus multi-cycle sequences.
module tb_except_ctrl;

  localparam logic [31:0] VB = 32'hBFC00380;
  localparam logic [31:0] VN = 32'h80000180;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_stall, mem_is_branch;
  logic [31:0] mem_pc, mem_badaddr;
  logic        mem_if_adel, mem_ri, mem_syscall, mem_break;
  logic        mem_ov, mem_adel, mem_ades, mem_eret;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        except_flush, except_eret, except_delayslot;
  logic [31:0] except_cur_pc, except_extra;
  logic [4:0]  except_code;

  except_ctrl_if rif ();

  except_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_stall(mem_stall),
    .mem_pc(mem_pc), .mem_is_branch(mem_is_branch),
    .mem_if_adel(mem_if_adel), .mem_ri(mem_ri),
    .mem_syscall(mem_syscall), .mem_break(mem_break),
    .mem_ov(mem_ov), .mem_adel(mem_adel),
    .mem_ades(mem_ades), .mem_eret(mem_eret),
    .mem_badaddr(mem_badaddr),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc),
    .except_flush(except_flush),
    .except_eret(except_eret),
    .except_delayslot(except_delayslot),
    .except_cur_pc(except_cur_pc),
    .except_code(except_code),
    .except_extra(except_extra),
    .rd(rif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pb;
    logic        vld;
    logic [31:0] pc;
    logic [7:0]  f;
    logic [31:0] bad;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] epc;
    logic        xf;
    logic        xe;
    logic [4:0]  xc;
    logic [31:0] xx;
    logic        xd;
    logic [31:0] xr;
  } vec_t;

  typedef struct {
    logic        f;
    logic        e;
    logic        d;
    logic [4:0]  c;
    logic [31:0] x;
    logic [31:0] p;
    logic [31:0] r;
  } exp_t;

  vec_t v [14];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_mem(input logic vld, input logic br,
                         input logic [31:0] pc,
                         input logic [7:0] f,
                         input logic [31:0] bad);
    mem_valid     = vld;
    mem_is_branch = br;
    mem_pc        = pc;
    {mem_if_adel, mem_ri, mem_syscall, mem_break,
     mem_ov, mem_adel, mem_ades, mem_eret} = f;
    mem_badaddr   = bad;
  endtask

  task automatic set_cp0(input logic [31:0] st,
                         input logic [31:0] ca,
                         input logic [31:0] epc);
    cp0_status = st;
    cp0_cause  = ca;
    cp0_epc    = epc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    mem_stall = 1'b0;
    rif.redirect_ready = 1'b0;
    set_mem(1'b1, 1'b0, 32'h80001000, 8'h20, 32'h0);
    set_cp0(32'h0, 32'h0, 32'h0);

    v[0]  = '{0, 1, 32'h80001000, 8'h20, 32'h0,
              32'h0, 32'h0, 32'h0,
              1, 0, 5'd8, 32'h0, 0, VN};
    v[1]  = '{1, 1, 32'h80000014, 8'h08, 32'h0,
              32'h0, 32'h0, 32'h0,
              1, 0, 5'd12, 32'h0, 1, VN};
    v[2]  = '{0, 1, 32'h80000020, 8'h42, 32'h1003,
              32'h0, 32'h0, 32'h0,
              1, 0, 5'd10, 32'h0, 0, VN};
    v[3]  = '{0, 1, 32'h80000024, 8'h04, 32'h80002001,
              32'h0, 32'h0, 32'h0,
              1, 0, 5'd4, 32'h80002001, 0, VN};
    v[4]  = '{0, 1, 32'h80000028, 8'h02, 32'h80002002,
              32'h0, 32'h0, 32'h0,
              1, 0, 5'd5, 32'h80002002, 0, VN};
    v[5]  = '{0, 1, 32'h80000030, 8'h00, 32'h0,
              32'h8001, 32'h8000, 32'h0,
              1, 0, 5'd0, 32'h0, 0, VN};
    v[6]  = '{0, 1, 32'h80000034, 8'h00, 32'h0,
              32'h8003, 32'h8000, 32'h0,
              0, 0, 5'd0, 32'h0, 0, 32'h0};
    v[7]  = '{0, 1, 32'h80000038, 8'h01, 32'h0,
              32'h0, 32'h0, 32'h80000400,
              1, 1, 5'd0, 32'h0, 0, 32'h80000400};
    v[8]  = '{0, 1, 32'hBFC00001, 8'h80, 32'h1234,
              32'h00400000, 32'h0, 32'h0,
              1, 0, 5'd4, 32'hBFC00001, 0, VB};
    v[9]  = '{0, 1, 32'h80000040, 8'h18, 32'h0,
              32'h0, 32'h0, 32'h0,
              1, 0, 5'd9, 32'h0, 0, VN};
    v[10] = '{0, 1, 32'h80000044, 8'hFF, 32'h55,
              32'h8001, 32'h8000, 32'h80000400,
              1, 0, 5'd0, 32'h0, 0, VN};
    v[11] = '{0, 1, 32'h80000048, 8'h03, 32'h80000008,
              32'h0, 32'h0, 32'h80000400,
              1, 0, 5'd5, 32'h80000008, 0, VN};
    v[12] = '{0, 0, 32'h8000004C, 8'h20, 32'h0,
              32'h0, 32'h0, 32'h0,
              0, 0, 5'd0, 32'h0, 0, 32'h0};
    v[13] = '{1, 1, 32'h80000054, 8'h01, 32'h0,
              32'h00400000, 32'h0, 32'h80000500,
              1, 1, 5'd0, 32'h0, 1, 32'h80000500};

    // reset state: request masked even with a cause present
    step();
    sample();
    chk("rst_flush", {31'h0, except_flush}, 32'h0);
    chk("rst_code", {27'h0, except_code}, 32'h0);
    chk("rst_rvalid", {31'h0, rif.redirect_valid}, 32'h0);
    chk("rst_rpc", rif.redirect_pc, 32'h0);
    step();
    rst = 1'b0;
    set_mem(1'b0, 1'b0, 32'h0, 8'h0, 32'h0);
    step();

    // table vectors: preload cycle, request cycle, cleanup
    for (int i = 0; i < 14; i++) begin
      set_cp0(v[i].st, v[i].ca, v[i].epc);
      set_mem(1'b1, v[i].pb, v[i].pc - 32'd4, 8'h0, 32'h0);
      rif.redirect_ready = 1'b0;
      step();
      set_mem(v[i].vld, 1'b0, v[i].pc, v[i].f, v[i].bad);
      sb.push_back('{v[i].xf, v[i].xe, v[i].xd, v[i].xc,
                     v[i].xx, v[i].xf ? v[i].pc : 32'h0,
                     v[i].xr});
      sample();
      e = sb.pop_front();
      chk($sformatf("v%0d_flush", i), {31'h0, except_flush},
          {31'h0, e.f});
      chk($sformatf("v%0d_eret", i), {31'h0, except_eret},
          {31'h0, e.e});
      chk($sformatf("v%0d_code", i), {27'h0, except_code},
          {27'h0, e.c});
      chk($sformatf("v%0d_extra", i), except_extra, e.x);
      chk($sformatf("v%0d_ds", i), {31'h0, except_delayslot},
          {31'h0, e.d});
      chk($sformatf("v%0d_curpc", i), except_cur_pc, e.p);
      step();
      set_mem(1'b0, 1'b0, 32'h0, 8'h0, 32'h0);
      set_cp0(32'h0, 32'h0, 32'h0);
      sample();
      chk($sformatf("v%0d_rvalid", i),
          {31'h0, rif.redirect_valid}, {31'h0, e.f});
      if (e.f)
        chk($sformatf("v%0d_rpc", i), rif.redirect_pc, e.r);
      rif.redirect_ready = 1'b1;
      step();
    end

    // redirect held while fetch stalls; no second flush
    rif.redirect_ready = 1'b0;
    set_mem(1'b1, 1'b0, 32'h80001000, 8'h20, 32'h0);
    sample();
    chk("h_flush", {31'h0, except_flush}, 32'h1);
    step();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("h_rvalid%0d", k),
          {31'h0, rif.redirect_valid}, 32'h1);
      chk($sformatf("h_rpc%0d", k), rif.redirect_pc, VN);
      chk($sformatf("h_noflush%0d", k),
          {31'h0, except_flush}, 32'h0);
      step();
    end
    set_mem(1'b0, 1'b0, 32'h0, 8'h0, 32'h0);
    rif.redirect_ready = 1'b1;
    sample();
    chk("h_rvalid_acc", {31'h0, rif.redirect_valid}, 32'h1);
    step();
    sample();
    chk("h_idle", {31'h0, rif.redirect_valid}, 32'h0);

    // stall holds the cause and the delay-slot flag
    set_mem(1'b1, 1'b1, 32'h80000060, 8'h0, 32'h0);
    step();
    mem_stall = 1'b1;
    set_mem(1'b1, 1'b0, 32'h80000064, 8'h08, 32'h0);
    sample();
    chk("s_noflush", {31'h0, except_flush}, 32'h0);
    step();
    mem_stall = 1'b0;
    sample();
    chk("s_flush", {31'h0, except_flush}, 32'h1);
    chk("s_ds", {31'h0, except_delayslot}, 32'h1);
    chk("s_code", {27'h0, except_code}, 32'd12);
    step();
    set_mem(1'b0, 1'b0, 32'h0, 8'h0, 32'h0);
    step();

    // ERET redirect aborted by reset
    set_cp0(32'h0, 32'h0, 32'h80000400);
    rif.redirect_ready = 1'b0;
    set_mem(1'b1, 1'b0, 32'h80000070, 8'h01, 32'h0);
    sample();
    chk("r_eret", {31'h0, except_eret}, 32'h1);
    step();
    sample();
    chk("r_rpc", rif.redirect_pc, 32'h80000400);
    rst = 1'b1;
    step();
    sample();
    chk("r_rvalid", {31'h0, rif.redirect_valid}, 32'h0);
    chk("r_rpc0", rif.redirect_pc, 32'h0);
    chk("r_flush", {31'h0, except_flush}, 32'h0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
